// File: rtl/crc16_pkg.sv
// Shared constants, FSM state encoding and result record for the CRC16 frame scheduler.
package crc16_pkg;

    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_INIT   = 16'hFFFF;
    localparam logic [15:0] DEF_XOROUT = 16'h0000;

    // Wide enough for the largest supported requester count (8).
    localparam int MAX_IDW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0]        value;
        logic [MAX_IDW-1:0] id;
        logic               abort;
    } crc_result_t;

endpackage

// File: rtl/crc16_word_step.sv
// One full 16-bit CRC step: sixteen serial MSB-first polynomial shifts, unrolled.
module crc16_word_step
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = DEF_POLY
) (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    always_comb begin
        logic [15:0] r;
        // NOTE: blocking assignments here chain the sixteen shifts within one evaluation.
        r = din;
        for (int i = 0; i < 16; i++) begin
            r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
        end
        dout = r;
    end

endmodule

// File: rtl/crc16_frame_sched.sv
// Round-robin scheduler sharing one CRC16 word engine between NREQ requesters, a frame at a time.
// Optional stall timeout enabled by defining CRC16_SCHED_TIMEOUT_EN.
module crc16_frame_sched
    import crc16_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter int          IDW     = 2,
    parameter logic [15:0] POLY    = DEF_POLY,
    parameter logic [15:0] INIT    = DEF_INIT,
    parameter logic [15:0] XOROUT  = DEF_XOROUT,
    parameter int          TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*16-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               crc_valid,
    output logic [15:0]        crc_value,
    output logic [IDW-1:0]     crc_id,
    output logic               crc_abort,
    input  logic               crc_ready,
    output logic               busy
);

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 2) begin : g_cfg_err
        $error("crc16_frame_sched: unsupported NREQ/IDW/TIMEOUT combination");
    end

    state_t           state, state_nxt;
    logic [IDW-1:0]   grant, rr_ptr, pick, cand;
    logic             found, hs, last_hs, res_hs, timeout_hit;
    int               idx;
    logic [15:0]      crc, sel_data, step_in, step_out;
    logic             valid_q;
    crc_result_t      res_q;
    logic             res_unused;

    // Round-robin search starting at rr_ptr and wrapping past NREQ-1.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_data = req_data[16*int'(grant) +: 16];
    assign step_in  = crc ^ sel_data;
    assign hs       = (state == ST_RUN) && req_valid[grant];
    assign last_hs  = hs && req_last[grant];
    assign res_hs   = valid_q && crc_ready;

    crc16_word_step #(.POLY(POLY)) u_step (
        .din  (step_in),
        .dout (step_out)
    );

`ifdef CRC16_SCHED_TIMEOUT_EN
    localparam int STW = $clog2(TIMEOUT);
    logic [STW-1:0] stall_cnt;

    assign timeout_hit = (state == ST_RUN) && !hs && (stall_cnt == STW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state != ST_RUN || hs) begin
            stall_cnt <= '0;
        end else if (!timeout_hit) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (|req_valid)            state_nxt = ST_RUN;
            ST_RUN:  if (last_hs || timeout_hit) state_nxt = ST_DONE;
            ST_DONE: if (res_hs)                state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant   <= '0;
            rr_ptr  <= '0;
            crc     <= INIT;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        crc   <= INIT;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        crc <= step_out;
                    end
                    if (last_hs) begin
                        valid_q     <= 1'b1;
                        res_q.value <= step_out ^ XOROUT;
                        res_q.id    <= MAX_IDW'(grant);
                        res_q.abort <= 1'b0;
                    end else if (timeout_hit) begin
                        // Aborted frame reports the partial CRC accumulated so far.
                        valid_q     <= 1'b1;
                        res_q.value <= crc ^ XOROUT;
                        res_q.id    <= MAX_IDW'(grant);
                        res_q.abort <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_hs) begin
                        valid_q     <= 1'b0;
                        res_q.abort <= 1'b0;
                        rr_ptr      <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_RUN) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign crc_valid  = valid_q;
    assign crc_value  = res_q.value;
    assign crc_id     = res_q.id[IDW-1:0];
    assign crc_abort  = res_q.abort;
    assign busy       = (state != ST_IDLE);
    assign res_unused = ^res_q;

endmodule

// File: tb/tb_crc16_frame_sched.sv
// Self-checking bench for crc16_frame_sched: directed vector table, corner sequences, random frames.
module tb_crc16_frame_sched;

    localparam int          NREQ = 4;
    localparam int          IDW  = 2;
    localparam int          TMO  = 8;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] INIT = 16'hFFFF;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*16-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_last = '0;
    logic                crc_ready = 1'b0;

    logic [NREQ-1:0]     req_ready;
    logic                crc_valid, crc_abort, busy;
    logic [15:0]         crc_value;
    logic [IDW-1:0]      crc_id;

    logic [NREQ-1:0]     z_ready_unused;
    logic                z_crc_valid, z_abort_unused, z_busy_unused;
    logic [15:0]         z_crc_value;
    logic [IDW-1:0]      z_crc_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crc16_frame_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .crc_valid(crc_valid), .crc_value(crc_value), .crc_id(crc_id),
        .crc_abort(crc_abort), .crc_ready(crc_ready), .busy(busy)
    );

    crc16_frame_sched #(.NREQ(NREQ), .IDW(IDW), .INIT(16'h0000), .TIMEOUT(TMO)) dut_i0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(z_ready_unused), .crc_valid(z_crc_valid), .crc_value(z_crc_value),
        .crc_id(z_crc_id), .crc_abort(z_abort_unused), .crc_ready(crc_ready), .busy(z_busy_unused)
    );

    // Reference: remainder of (crc ^ data) * x^16 modulo the degree-16 generator, by GF(2) long division.
    function automatic logic [15:0] mstep(input logic [15:0] c, input logic [15:0] d);
        logic [31:0] v;
        logic [31:0] g;
        v = {c ^ d, 16'h0000};
        g = {15'd0, 1'b1, POLY};
        for (int b = 31; b >= 16; b--) begin
            if (v[b]) v = v ^ (g << (b - 16));
        end
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; crc_ready = 1'b0;
        @(negedge clk);
        check("rst_crc_valid", crc_valid, 0);
        check("rst_crc_value", crc_value, 0);
        check("rst_crc_id",    crc_id, 0);
        check("rst_crc_abort", crc_abort, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy",      busy, 0);
        rst = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the word's handshake.
    task automatic send_word(input int id, input logic [15:0] d, input logic l);
        int n = 0;
        req_valid[id] = 1'b1;
        req_data[16*id +: 16] = d;
        req_last[id] = l;
        #1;
        while (!req_ready[id] && n < 64) begin
            @(negedge clk); #1; n++;
        end
        check("word_accepted", req_ready[id], 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic get_result(output logic [15:0] v, output logic [IDW-1:0] id,
                              output logic ab, output logic [15:0] zv);
        int n = 0;
        while (!crc_valid && n < 64) begin
            @(negedge clk); n++;
        end
        check("result_seen", crc_valid, 1);
        v = crc_value; id = crc_id; ab = crc_abort; zv = z_crc_value;
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [15:0] exp_def;
        logic [15:0] exp_i0;
    } vec_t;

    vec_t vecs[6];

    logic [15:0] wq[NREQ][$];
    logic        lq[NREQ][$];
    logic [15:0] ed[NREQ][$];
    logic [15:0] ez[NREQ][$];
    logic        acc[NREQ];
    logic        mid[NREQ];

    initial begin
        logic [15:0]    v, zv, d4[5];
        logic [IDW-1:0] id;
        logic           ab;
        int             n;
        int             ids[$];
        logic [15:0]    vals[$];
        logic           reused0;

        vecs[0] = '{0, 16'h0001, mstep(INIT, 16'h0001), 16'h1021};
        vecs[1] = '{2, 16'hFFFF, 16'h0000, mstep(16'h0000, 16'hFFFF)};
        vecs[2] = '{1, 16'hA5A5, mstep(INIT, 16'hA5A5), mstep(16'h0000, 16'hA5A5)};
        vecs[3] = '{3, 16'h0000, mstep(INIT, 16'h0000), 16'h0000};
        vecs[4] = '{0, 16'h8000, mstep(INIT, 16'h8000), mstep(16'h0000, 16'h8000)};
        vecs[5] = '{3, 16'h1234, mstep(INIT, 16'h1234), mstep(16'h0000, 16'h1234)};

        // Directed one-word frames, one requester at a time.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].id, vecs[i].data, 1'b1);
            check("vec_latency", crc_valid, 1);
            get_result(v, id, ab, zv);
            check("vec_id",    id, vecs[i].id);
            check("vec_value", v,  vecs[i].exp_def);
            check("vec_i0",    zv, vecs[i].exp_i0);
            check("vec_abort", ab, 0);
        end

        // Reset mid-frame: outputs clear at once and the round-robin pointer returns to 0.
        do_reset();
        send_word(2, 16'h1234, 1'b1);
        get_result(v, id, ab, zv);
        check("rm_first_id", id, 2);
        send_word(3, 16'hAAAA, 1'b0);
        check("rm_busy_run", busy, 1);
        rst = 1'b0;
        #1;
        check("rm_busy",      busy, 0);
        check("rm_crc_valid", crc_valid, 0);
        check("rm_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        req_valid[3] = 1'b1; req_data[48 +: 16] = 16'h5555; req_last[3] = 1'b1;
        send_word(0, 16'h0BAD, 1'b1);
        get_result(v, id, ab, zv);
        check("rm_rr_id",    id, 0);
        check("rm_rr_value", v, mstep(INIT, 16'h0BAD));
        send_word(3, 16'h5555, 1'b1);
        get_result(v, id, ab, zv);
        check("rm_next_id",    id, 3);
        check("rm_next_value", v, mstep(INIT, 16'h5555));

        // All four requesters valid with one-word frames and crc_ready held high.
        do_reset();
        for (int r = 0; r < 5; r++) d4[r] = 16'($urandom);
        crc_ready = 1'b1;
        req_valid = '1; req_last = '1;
        for (int r = 0; r < NREQ; r++) req_data[16*r +: 16] = d4[r];
        reused0 = 1'b0;
        n = 0;
        while (ids.size() < 5 && n < 100) begin
            int a;
            a = -1;
            #1;
            check("rr_onehot", ($countones(req_ready) <= 1), 1);
            for (int r = 0; r < NREQ; r++) if (req_valid[r] && req_ready[r]) a = r;
            if (crc_valid) begin
                ids.push_back(int'(crc_id));
                vals.push_back(crc_value);
            end
            @(negedge clk);
            n++;
            if (a == 0 && !reused0) begin
                reused0 = 1'b1;
                req_data[15:0] = d4[4];
            end else if (a >= 0) begin
                req_valid[a] = 1'b0;
            end
        end
        crc_ready = 1'b0;
        req_valid = '0; req_last = '0;
        check("rr_count", ids.size(), 5);
        for (int k = 0; k < 5 && k < ids.size(); k++) begin
            check("rr_order", ids[k], k % NREQ);
            check("rr_value", vals[k], mstep(INIT, (k == 4) ? d4[4] : d4[k]));
        end

        // Result backpressure with a second requester queued behind it.
        do_reset();
        send_word(0, 16'hC0DE, 1'b1);
        req_valid[1] = 1'b1; req_data[16 +: 16] = 16'h0101; req_last[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", crc_valid, 1);
            check("bp_value", crc_value, mstep(INIT, 16'hC0DE));
            check("bp_id",    crc_id, 0);
            check("bp_ready", req_ready, 0);
        end
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
        check("bp_idle_ready", req_ready, 0);
        check("bp_idle_busy",  busy, 0);
        @(negedge clk);
        check("bp_grant1", req_ready, 4'b0010);
        send_word(1, 16'h0101, 1'b1);
        get_result(v, id, ab, zv);
        check("bp_next_id",    id, 1);
        check("bp_next_value", v, mstep(INIT, 16'h0101));

`ifdef CRC16_SCHED_TIMEOUT_EN
        // Stall timeout: requester 3 stops after its first word.
        do_reset();
        send_word(3, 16'h3333, 1'b0);
        n = 0;
        while (!crc_valid && n < 40) begin
            @(negedge clk); n++;
        end
        check("to_cycles", n, TMO);
        check("to_abort",  crc_abort, 1);
        check("to_id",     crc_id, 3);
        check("to_value",  crc_value, mstep(INIT, 16'h3333));
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
`endif

        // Random multi-word frames from every requester with mid-frame bubbles and result backpressure.
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            acc[r] = 1'b0; mid[r] = 1'b0;
            for (int f = 0; f < 3; f++) begin
                logic [15:0] cd, cz, d;
                int nw;
                nw = 1 + int'($urandom_range(0, 3));
                cd = INIT; cz = 16'h0000;
                for (int w = 0; w < nw; w++) begin
                    d = 16'($urandom);
                    wq[r].push_back(d);
                    lq[r].push_back(w == nw - 1);
                    cd = mstep(cd, d);
                    cz = mstep(cz, d);
                end
                ed[r].push_back(cd);
                ez[r].push_back(cz);
            end
        end
        begin
            int got, mrr, cyc;
            got = 0; mrr = 0; cyc = 0;
            while (got < 12 && cyc < 4000) begin
                for (int r = 0; r < NREQ; r++) begin
                    if (acc[r]) begin
                        mid[r] = !lq[r][0];
                        void'(wq[r].pop_front());
                        void'(lq[r].pop_front());
                        acc[r] = 1'b0;
                    end
                end
                for (int r = 0; r < NREQ; r++) begin
                    logic bubble;
`ifdef CRC16_SCHED_TIMEOUT_EN
                    bubble = 1'b0;
`else
                    bubble = mid[r] && ($urandom_range(0, 3) == 0);
`endif
                    req_valid[r] = (wq[r].size() != 0) && !bubble;
                    req_data[16*r +: 16] = (wq[r].size() != 0) ? wq[r][0] : 16'h0000;
                    req_last[r] = (wq[r].size() != 0) ? lq[r][0] : 1'b0;
                end
                crc_ready = ($urandom_range(0, 2) != 0);
                #1;
                check("rnd_onehot", ($countones(req_ready) <= 1), 1);
                for (int r = 0; r < NREQ; r++) acc[r] = req_valid[r] & req_ready[r];
                if (crc_valid && crc_ready) begin
                    int e;
                    e = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        int r;
                        r = (mrr + k) % NREQ;
                        if (e < 0 && ed[r].size() != 0) e = r;
                    end
                    if (e < 0) begin
                        check("rnd_extra_result", got, 12);
                    end else begin
                        check("rnd_id",    crc_id, e);
                        check("rnd_value", crc_value, ed[e].pop_front());
                        check("rnd_i0",    z_crc_value, ez[e].pop_front());
                        check("rnd_i0_id", z_crc_id, e);
                        check("rnd_abort", crc_abort, 0);
                        mrr = (e + 1) % NREQ;
                    end
                    got++;
                end
                @(negedge clk);
                cyc++;
            end
            check("rnd_all_results", got, 12);
            req_valid = '0; req_last = '0; crc_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
